// File: rtl/adc_buffer_pkg.sv
// ============================================================================
//  Module   : adc_buffer_pkg
//  Purpose  : Shared defaults, FSM state encoding and tag-width helper for
//             the multi-channel ADC capture buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_buffer_pkg;

    localparam int c_def_data_w = 16;
    localparam int c_def_depth  = 1024;
    localparam int c_def_n_ch   = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    // Channel tag width; a single-channel build still carries one tag bit.
    function automatic int tag_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO with registered read data, occupancy count
//             and registered full/empty/almost-full flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync #(
    parameter int WIDTH     = 18,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full
);

    localparam int              c_aw     = $clog2(DEPTH);
    localparam int              c_cw     = c_aw + 1;
    localparam logic [c_cw-1:0] c_full   = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_af_thr = c_cw'(DEPTH - AF_MARGIN);
    localparam logic [c_cw-1:0] c_one    = c_cw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic [c_cw-1:0]  w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid    <= w_pop;
            r_count       <= w_count_nxt;
            r_full        <= (w_count_nxt == c_full);
            r_empty       <= (w_count_nxt == '0);
            r_almost_full <= (w_count_nxt > c_af_thr);
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_count       = r_count;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_almost_full = r_almost_full;

endmodule

`default_nettype wire

// File: rtl/adc_buffer_mc.sv
// ============================================================================
//  Module   : adc_buffer_mc
//  Purpose  : Captures whole N_CH-sample ADC frames into a tagged FIFO,
//             dropping frames that do not fit. Optional dropped-frame counter
//             enabled by defining ADC_BUFFER_OVF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_buffer_mc
    import adc_buffer_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int DEPTH  = c_def_depth,
    parameter int N_CH   = c_def_n_ch
) (
    input  logic                        clk_100MHz_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic                        adc_stb_i,
    input  logic [N_CH*DATA_W-1:0]      adc_data_i,
    input  logic                        rd_en_i,
    output logic [DATA_W-1:0]           dato_o,
    output logic [tag_w(N_CH)-1:0]      ch_o,
    output logic                        valid_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        almost_full_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        overflow_o,
    output logic [15:0]                 ovf_cnt_o
);

    localparam int                   c_tag_w    = tag_w(N_CH);
    localparam int                   c_cw       = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0]      c_room_thr = c_cw'(DEPTH - N_CH);
    localparam logic [c_tag_w-1:0]   c_last_ch  = c_tag_w'(N_CH - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_CH*DATA_W-1:0]   r_frame;
    logic [c_tag_w-1:0]       r_ch;
    logic [DATA_W-1:0]        w_chan [N_CH];
    logic                     w_strobe;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_wr;
    logic                     r_overflow;
    logic [c_cw-1:0]          w_count;
    logic [DATA_W+c_tag_w-1:0] w_rd_data;

    assign w_strobe = adc_stb_i & wr_en_i;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_chan
            assign w_chan[k] = r_frame[k*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Room is checked against the registered count; in IDLE no writes are in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    if (w_count <= c_room_thr) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_CAPTURE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                w_wr   = 1'b1;
                w_drop = w_strobe;
                if (r_ch == c_last_ch) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_frame <= '0;
            r_ch    <= '0;
        end else if (w_accept) begin
            r_frame <= adc_data_i;
            r_ch    <= '0;
        end else if (w_wr) begin
            r_ch <= r_ch + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef ADC_BUFFER_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt_o = r_ovf_cnt;
`else
    assign ovf_cnt_o = '0;
`endif

    fifo_sync #(
        .WIDTH     (DATA_W + c_tag_w),
        .DEPTH     (DEPTH),
        .AF_MARGIN (N_CH)
    ) u_fifo (
        .clk           (clk_100MHz_i),
        .rst           (rst_i),
        .i_wr_en       (w_wr),
        .i_wr_data     ({r_ch, w_chan[r_ch]}),
        .i_rd_en       (rd_en_i),
        .o_rd_data     (w_rd_data),
        .o_rd_valid    (valid_o),
        .o_count       (w_count),
        .o_full        (full_o),
        .o_empty       (empty_o),
        .o_almost_full (almost_full_o)
    );

    assign count_o    = w_count;
    assign dato_o     = w_rd_data[DATA_W-1:0];
    assign ch_o       = w_rd_data[DATA_W +: c_tag_w];
    assign overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adc_buffer_mc.sv
// ============================================================================
//  Module   : tb_adc_buffer_mc
//  Purpose  : Scoreboard bench for adc_buffer_mc (DATA_W=16, DEPTH=16, N_CH=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_buffer_mc;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int N_CH   = 4;

    logic                   clk_100MHz_i = 1'b0;
    logic                   rst_i;
    logic                   wr_en_i;
    logic                   adc_stb_i;
    logic [N_CH*DATA_W-1:0] adc_data_i;
    logic                   rd_en_i;
    logic [DATA_W-1:0]      dato_o;
    logic [1:0]             ch_o;
    logic                   valid_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   almost_full_o;
    logic [4:0]             count_o;
    logic                   overflow_o;
    logic [15:0]            ovf_cnt_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];
    int          max_cnt;

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    adc_buffer_mc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_CH   (N_CH)
    ) dut (
        .clk_100MHz_i  (clk_100MHz_i),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .adc_stb_i     (adc_stb_i),
        .adc_data_i    (adc_data_i),
        .rd_en_i       (rd_en_i),
        .dato_o        (dato_o),
        .ch_o          (ch_o),
        .valid_o       (valid_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .ovf_cnt_o     (ovf_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ovf_exp(input int n);
`ifdef ADC_BUFFER_OVF_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [63:0] mk_frame(input logic [15:0] base);
        logic [63:0] d;
        for (int k = 0; k < N_CH; k++) begin
            d[k*16 +: 16] = base + 16'(k);
        end
        return d;
    endfunction

    // Monitor: every presented word must match the oldest expected word.
    always @(negedge clk_100MHz_i) begin
        if (!rst_i && valid_o) begin : mon
            logic [17:0] e;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got ch=%0d data=%h, nothing expected", ch_o, dato_o);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", {16'h0, dato_o}, {16'h0, e[15:0]});
                chk("pop_ch", {30'h0, ch_o}, {30'h0, e[17:16]});
            end
        end
    end

    task automatic tick();
        @(posedge clk_100MHz_i);
        #1;
    endtask

    task automatic strobe(input logic [63:0] d, input bit exp_acc);
        adc_stb_i  = 1'b1;
        adc_data_i = d;
        if (exp_acc) begin
            for (int k = 0; k < N_CH; k++) begin
                exp_q.push_back({2'(k), d[k*16 +: 16]});
            end
        end
        tick();
        adc_stb_i  = 1'b0;
        adc_data_i = 64'hDEAD_BEEF_CAFE_F00D;
    endtask

    task automatic frame(input logic [63:0] d);
        strobe(d, 1'b1);
        repeat (N_CH) tick();
    endtask

    task automatic pop_n(input int n);
        rd_en_i = 1'b1;
        repeat (n) tick();
        rd_en_i = 1'b0;
        tick();
    endtask

    task automatic tick_track();
        tick();
        if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    endtask

    initial begin
        rst_i      = 1'b1;
        wr_en_i    = 1'b0;
        adc_stb_i  = 1'b0;
        adc_data_i = '0;
        rd_en_i    = 1'b0;
        repeat (2) tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_af", almost_full_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_ovf_cnt", ovf_cnt_o, 0);
        rst_i = 1'b0;
        tick();

        // Single frame, then drain in order.
        wr_en_i = 1'b1;
        frame(64'h0004_0003_0002_0001);
        chk("t1_count", count_o, 4);
        pop_n(4);
        chk("t1_empty", empty_o, 1);
        chk("t1_count0", count_o, 0);

        // Fill to full, fifth frame dropped.
        for (int i = 0; i < 4; i++) frame(mk_frame(16'h1000 + 16'(i * 16)));
        chk("t2_full", full_o, 1);
        chk("t2_count", count_o, 16);
        chk("t2_af", almost_full_o, 1);
        strobe(mk_frame(16'h1F00), 1'b0);
        chk("t2_ovf", overflow_o, 1);
        chk("t2_ovf_cnt", ovf_cnt_o, ovf_exp(1));
        chk("t2_count_hold", count_o, 16);
        pop_n(16);
        chk("t2_empty", empty_o, 1);
        chk("t2_notfull", full_o, 0);

        // Occupancy 13: a frame no longer fits.
        for (int i = 0; i < 4; i++) frame(mk_frame(16'h2000 + 16'(i * 16)));
        pop_n(3);
        chk("t3_count13", count_o, 13);
        chk("t3_af13", almost_full_o, 1);
        strobe(mk_frame(16'h2F00), 1'b0);
        repeat (4) tick();
        chk("t3_count_hold", count_o, 13);
        chk("t3_af", almost_full_o, 1);
        chk("t3_ovf_cnt", ovf_cnt_o, ovf_exp(2));
        pop_n(13);
        chk("t3_empty", empty_o, 1);

        // Strobe during capture dropped; wr_en low mid-frame still completes.
        strobe(mk_frame(16'h3000), 1'b1);
        strobe(mk_frame(16'h3100), 1'b0);
        wr_en_i = 1'b0;
        repeat (3) tick();
        chk("t4_count", count_o, 4);
        chk("t4_ovf_cnt", ovf_cnt_o, ovf_exp(3));
        strobe(mk_frame(16'h3200), 1'b0);
        repeat (4) tick();
        chk("t4_ign_count", count_o, 4);
        chk("t4_ign_ovf_cnt", ovf_cnt_o, ovf_exp(3));
        wr_en_i = 1'b1;
        pop_n(4);

        // Continuous reads across pointer wraparound.
        max_cnt = 0;
        rd_en_i = 1'b1;
        for (int f = 0; f < 6; f++) begin
            strobe(mk_frame(16'h4000 + 16'(f * 16)), 1'b1);
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
            repeat (4) tick_track();
        end
        repeat (3) tick_track();
        rd_en_i = 1'b0;
        tick();
        chk("t5_max_count", max_cnt, 1);
        chk("t5_empty", empty_o, 1);

        // Reset in the middle of a capture.
        strobe(mk_frame(16'h5000), 1'b1);
        repeat (2) tick();
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_count", count_o, 0);
        chk("t6_empty", empty_o, 1);
        chk("t6_valid", valid_o, 0);
        chk("t6_dato", dato_o, 0);
        chk("t6_ch", ch_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_ovf_cnt", ovf_cnt_o, 0);
        tick();
        rst_i = 1'b0;
        repeat (5) tick();
        chk("t6_no_write", count_o, 0);
        chk("t6_empty_after", empty_o, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_buffer_mc.md
ADC_BUFFER_MC -- requirements
Module: adc_buffer_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, FIFO words; power of two, >= 2*N_CH.
REQ-003 SHALL have parameter N_CH, default 4, ADC channels per frame; 1..8.
REQ-004 SHALL have port clk_100MHz_i  in  1  single system clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en_i  in  1  capture enable; strobes ignored while low.
REQ-007 SHALL have port adc_stb_i  in  1  one-cycle pulse: new frame on adc_data_i.
REQ-008 SHALL have port adc_data_i  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port rd_en_i  in  1  pop request.
REQ-010 SHALL have port dato_o  out  DATA_W  popped sample.
REQ-011 SHALL have port ch_o  out  max(1,clog2(N_CH))  channel tag of dato_o.
REQ-012 SHALL have port valid_o  out  1  dato_o/ch_o valid this cycle.
REQ-013 SHALL have ports full_o, empty_o, almost_full_o  out  1 each  status flags.
REQ-014 SHALL have ports count_o  out  clog2(DEPTH)+1  occupancy; overflow_o  out  1  sticky drop flag; ovf_cnt_o  out  16  dropped-frame count.

Function
REQ-015 SHALL use FSM IDLE/CAPTURE: IDLE->CAPTURE on accepted strobe; CAPTURE writes channel k (k=0..N_CH-1) one word per cycle with tag k; ->IDLE after channel N_CH-1.
REQ-016 SHALL latch adc_data_i entire on the accepting strobe cycle; later adc_data_i changes do not affect the frame.
REQ-017 SHALL accept a strobe only when wr_en_i=1, FSM in IDLE, and DEPTH-count_o >= N_CH on that cycle.
REQ-018 SHALL drop the whole frame (no partial frames) when the strobe is not accepted with wr_en_i=1; drop sets overflow_o and increments ovf_cnt_o.
REQ-019 SHALL deassert wr_en_i effect only at frame boundaries: a capture in progress completes.
REQ-020 SHALL pop on rd_en_i=1 and empty_o=0; dato_o/ch_o registered, valid_o=1 exactly one cycle after the pop; rd_en_i on empty ignored, valid_o=0.
REQ-021 SHALL support same-cycle write and pop; count_o unchanged then.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full_o when count_o=DEPTH, empty_o when 0.
REQ-023 SHALL assert almost_full_o when count_o > DEPTH-N_CH (next frame would drop).
REQ-024 SHALL saturate ovf_cnt_o at 16'hFFFF.
REQ-025 SHALL update all flags and count_o registered, same cycle as the pointer change.

Reset
REQ-026 SHALL on rst_i=1, asynchronously: FSM=IDLE, pointers=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0, valid_o=0, dato_o=0, ch_o=0, overflow_o=0, ovf_cnt_o=0.
REQ-027 SHALL abandon a capture in progress on reset; partial frame discarded.
REQ-028 SHALL not require RAM contents cleared.

Configuration
REQ-029 SHALL compile ovf_cnt_o counter only with ADC_BUFFER_OVF_CNT_EN defined.
REQ-030 SHALL without ADC_BUFFER_OVF_CNT_EN keep port ovf_cnt_o tied to 0; overflow_o unaffected.

Structure
REQ-031 SHALL place FSM state enum, default DATA_W/DEPTH/N_CH, and tag-width function in package adc_buffer_pkg.
REQ-032 SHALL instantiate one sub-module fifo_sync (storage DATA_W+tag bits, pointers, count, flags).

Verification (DATA_W=16, DEPTH=16, N_CH=4)
REQ-033 SHALL: reset, wr_en_i=1, one strobe with data {16'h0004,16'h0003,16'h0002,16'h0001} -> count_o=4 after 4 cycles; 4 pops -> dato_o 1,2,3,4, ch_o 0..3, empty_o=1.
REQ-034 SHALL: 4 accepted strobes, no reads -> full_o=1, count_o=16; 5th strobe -> dropped, overflow_o=1, ovf_cnt_o=1 (0 without macro).
REQ-035 SHALL: count_o=13, strobe -> whole frame dropped, count_o stays 13, almost_full_o=1.
REQ-036 SHALL: strobe during CAPTURE -> dropped and counted; strobe with wr_en_i=0 -> ignored, no count.
REQ-037 SHALL: continuous rd_en_i during frame writes past pointer wraparound (>=5 frames) -> data order preserved, count_o never exceeds 16.
REQ-038 SHALL: rst_i asserted mid-CAPTURE -> all outputs at reset values same cycle, no further writes.
